// File: rtl/arbitro_rr.sv
// arbitro_rr: fixed-priority / round-robin arbiter moving head words from N_IN input FIFOs to N_OUT output FIFOs
module arbitro_rr #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 4,
  parameter int SEL_W = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   modo,
  input  logic [N_IN-1:0]        empty,
  input  logic [N_IN*SEL_W-1:0]  head_dest,
  input  logic [N_OUT-1:0]       full,
  output logic [N_IN-1:0]        pop,
  output logic [N_OUT-1:0]       push,
  output logic [SEL_W-1:0]       demux,
  output logic                   idle
);
  localparam int NS = 1 << SEL_W;
  logic [SEL_W-1:0] last_q, last_d, demux_q, demux_d, pdest_q, pdest_d, gnt_idx, gnt_dest, dst;
  logic             pend_q, pend_d, gnt_ok;
  logic [NS-1:0]    dest_ok;
  logic [N_IN-1:0]  elig;
  int               j;
  // out-of-range destinations stay zero in dest_ok, so such inputs are never eligible
  always_comb begin
    dest_ok = '0;
    dest_ok[N_OUT-1:0] = ~full;
    elig = '0;
    dst = '0;
    for (int i = 0; i < N_IN; i++) begin
      dst = head_dest[i*SEL_W +: SEL_W];
      elig[i] = !empty[i] && dest_ok[dst] && !(pend_q && dst == pdest_q);
    end
  end
  always_comb begin
    gnt_ok = 1'b0;
    gnt_idx = '0;
    j = 0;
    for (int k = 0; k < N_IN; k++) begin
      j = modo ? (int'(last_q) + 1 + k) % N_IN : k;
      if (!gnt_ok && elig[j]) begin
        gnt_ok = 1'b1;
        gnt_idx = SEL_W'(j);
      end
    end
  end
  assign gnt_dest = head_dest[int'(gnt_idx)*SEL_W +: SEL_W];
  always_comb begin
    pop = '0;
    if (gnt_ok && !reset) pop[gnt_idx] = 1'b1;
    push = '0;
    if (pend_q && !reset) push[pdest_q] = 1'b1;
  end
  assign demux   = reset ? '0 : demux_q;
  assign idle    = reset || (!gnt_ok && !pend_q);
  assign pend_d  = gnt_ok;
  assign pdest_d = gnt_ok ? gnt_dest : pdest_q;
  assign demux_d = gnt_ok ? gnt_idx : demux_q;
  assign last_d  = gnt_ok ? gnt_idx : last_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q  <= 1'b0;
      pdest_q <= '0;
      demux_q <= '0;
      last_q  <= SEL_W'(N_IN - 1);
    end else begin
      pend_q  <= pend_d;
      pdest_q <= pdest_d;
      demux_q <= demux_d;
      last_q  <= last_d;
    end
  end
endmodule

// File: tb/tb_arbitro_rr.sv
// tb_arbitro_rr: vector table for pop/idle plus a push/demux scoreboard one cycle behind
module tb_arbitro_rr;
  logic        clk = 1'b0, reset = 1'b1, modo = 1'b0;
  logic [3:0]  empty = 4'hf, full = '0, pop, push;
  logic [11:0] head_dest = '0;
  logic [2:0]  demux;
  logic        idle;
  int          n_tests = 0, n_fail = 0;
  typedef struct {
    logic rst, md;
    logic [3:0] emp;
    logic [11:0] hd;
    logic [3:0] fl, exp_pop;
    logic exp_idle;
  } vec_t;
  typedef struct {
    logic [3:0] push;
    logic [2:0] demux;
  } exp_t;
  vec_t vecs[$];
  exp_t sb[$];
  arbitro_rr #(.N_IN(4), .N_OUT(4), .SEL_W(3)) dut (
    .clk(clk), .reset(reset), .modo(modo), .empty(empty), .head_dest(head_dest),
    .full(full), .pop(pop), .push(push), .demux(demux), .idle(idle)
  );
  always #5 clk = ~clk;
  function automatic logic [11:0] hd(input int d3, input int d2, input int d1, input int d0);
    return {3'(d3), 3'(d2), 3'(d1), 3'(d0)};
  endfunction
  task automatic add(input logic r, input logic m, input logic [3:0] e, input logic [11:0] h,
                     input logic [3:0] f, input logic [3:0] p, input logic i);
    vecs.push_back('{r, m, e, h, f, p, i});
  endtask
  task automatic chk(input int row, input string nm, input logic [3:0] got, input logic [3:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL row%0d %s got %b expected %b", row, nm, got, exp);
    end
  endtask
  initial begin
    logic [11:0] e4;
    logic [2:0]  last_dmx, idx, dst;
    exp_t        ex;
    e4 = hd(3, 2, 1, 0);
    add(1, 1, 4'b0000, e4, 4'b0000, 4'b0000, 1);
    add(0, 1, 4'b0000, e4, 4'b0000, 4'b0001, 0);
    add(0, 1, 4'b0000, e4, 4'b0000, 4'b0010, 0);
    add(0, 1, 4'b0000, e4, 4'b0000, 4'b0100, 0);
    add(0, 1, 4'b0000, e4, 4'b0000, 4'b1000, 0);
    add(0, 1, 4'b0000, e4, 4'b0000, 4'b0001, 0);
    add(0, 0, 4'b0000, hd(3, 2, 1, 1), 4'b0000, 4'b0001, 0);
    add(0, 0, 4'b0000, hd(3, 2, 1, 2), 4'b0000, 4'b0001, 0);
    add(0, 0, 4'b0000, hd(3, 2, 1, 3), 4'b0000, 4'b0001, 0);
    add(1, 1, 4'b1100, hd(0, 0, 2, 2), 4'b0000, 4'b0000, 1);
    add(0, 1, 4'b1100, hd(0, 0, 2, 2), 4'b0000, 4'b0001, 0);
    add(0, 1, 4'b1100, hd(0, 0, 2, 2), 4'b0000, 4'b0000, 0);
    add(0, 1, 4'b1100, hd(0, 0, 2, 2), 4'b0000, 4'b0010, 0);
    add(0, 1, 4'b1100, hd(0, 0, 2, 2), 4'b0000, 4'b0000, 0);
    add(0, 1, 4'b1111, hd(0, 0, 2, 2), 4'b0000, 4'b0000, 1);
    add(0, 0, 4'b1100, hd(0, 0, 0, 3), 4'b1000, 4'b0010, 0);
    add(0, 0, 4'b1100, hd(0, 0, 0, 3), 4'b0000, 4'b0001, 0);
    add(0, 1, 4'b0000, hd(1, 2, 5, 0), 4'b0000, 4'b0100, 0);
    add(0, 1, 4'b0000, hd(1, 2, 5, 0), 4'b0000, 4'b1000, 0);
    add(0, 1, 4'b0000, hd(1, 2, 5, 0), 4'b0000, 4'b0001, 0);
    add(0, 1, 4'b0000, hd(1, 2, 5, 0), 4'b0000, 4'b0100, 0);
    add(1, 1, 4'b0000, hd(1, 2, 5, 0), 4'b0000, 4'b0000, 1);
    add(0, 1, 4'b0000, hd(1, 2, 5, 0), 4'b0000, 4'b0001, 0);
    add(0, 0, 4'b0000, hd(1, 2, 5, 0), 4'b0000, 4'b0100, 0);
    add(0, 0, 4'b1111, hd(1, 2, 5, 0), 4'b0000, 4'b0000, 0);
    add(0, 0, 4'b1111, hd(1, 2, 5, 0), 4'b0000, 4'b0000, 1);
    add(0, 1, 4'b0000, e4, 4'b1111, 4'b0000, 1);
    last_dmx = '0;
    sb.push_back('{4'b0000, 3'd0});
    @(posedge clk);
    #1;
    foreach (vecs[k]) begin
      reset = vecs[k].rst; modo = vecs[k].md; empty = vecs[k].emp;
      head_dest = vecs[k].hd; full = vecs[k].fl;
      @(negedge clk);
      ex = sb.pop_front();
      if (vecs[k].rst) ex = '{4'b0000, 3'd0};
      chk(k, "pop", pop, vecs[k].exp_pop);
      chk(k, "idle", {3'b0, idle}, {3'b0, vecs[k].exp_idle});
      chk(k, "push", push, ex.push);
      chk(k, "demux", {1'b0, demux}, {1'b0, ex.demux});
      if (vecs[k].rst) last_dmx = '0;
      if (!vecs[k].rst && vecs[k].exp_pop != 0) begin
        idx = '0;
        for (int b = 0; b < 4; b++) if (vecs[k].exp_pop[b]) idx = 3'(b);
        dst = vecs[k].hd[int'(idx)*3 +: 3];
        last_dmx = idx;
        sb.push_back('{4'(1 << dst), idx});
      end else begin
        sb.push_back('{4'b0000, last_dmx});
      end
      @(posedge clk);
      #1;
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
